// File: rtl/phy_serdes_lanes_if.sv
// Parallel/serial signal bundle for phy_serdes_lanes.
// master = striping logic and serial link side, slave = the PHY.
interface phy_serdes_lanes_if #(
  parameter int LANES = 2,
  parameter int WIDTH = 8
);
  logic                   enable;
  logic [LANES*WIDTH-1:0] data_in;
  logic [LANES-1:0]       valid_in;
  logic                   word_strobe;
  logic [LANES-1:0]       serial_out;
  logic [LANES-1:0]       serial_in;
  logic [LANES*WIDTH-1:0] data_out;
  logic [LANES-1:0]       valid_out;
  logic [LANES-1:0]       active;

  modport master (
    output enable, data_in, valid_in, serial_in,
    input  word_strobe, serial_out, data_out, valid_out, active
  );

  modport slave (
    input  enable, data_in, valid_in, serial_in,
    output word_strobe, serial_out, data_out, valid_out, active
  );
endinterface

// File: rtl/phy_serdes_lanes.sv
// N-lane PHY datapath: per-lane TX serialiser with COM idle fill, RX deserialiser with COM alignment.
// Define PHY_LOOPBACK_EN to feed each RX lane from its own serial_out instead of serial_in.
module phy_serdes_lanes #(
  parameter int              LANES      = 2,
  parameter int              WIDTH      = 8,
  parameter logic [WIDTH-1:0] COM_CHAR  = WIDTH'(8'hBC),
  parameter int              SYNC_COUNT = 4
) (
  input  logic              clk_8f,
  input  logic              reset,
  phy_serdes_lanes_if.slave bus
);

  localparam int PH_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = $clog2(SYNC_COUNT + 1);
  localparam logic [PH_W-1:0]  LAST_BIT = PH_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] SYNC_CNT = CNT_W'(SYNC_COUNT);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } sync_state_e;

  // TX side
  logic [PH_W-1:0]              bit_cnt;
  logic                         load;
  logic [LANES-1:0][WIDTH-1:0]  tx_sh;
  logic [LANES-1:0]             serial_q;

  // RX side
  logic [LANES-1:0]             rx_bit;
  logic [LANES-1:0][WIDTH-1:0]  rx_sh;
  logic [PH_W-1:0]              rx_ph       [LANES];
  logic [CNT_W-1:0]             com_cnt     [LANES];
  logic [CNT_W-1:0]             com_cnt_nxt [LANES];
  sync_state_e                  state_q     [LANES];
  sync_state_e                  state_nxt   [LANES];
  logic [LANES-1:0]             is_com;
  logic [LANES-1:0]             at_bnd;
  logic [LANES-1:0]             ph_clr;
  logic [LANES-1:0][WIDTH-1:0]  dout_q;
  logic [LANES-1:0][WIDTH-1:0]  dout_nxt;
  logic [LANES-1:0]             vout_q;
  logic [LANES-1:0]             vout_nxt;
  logic [LANES-1:0]             active_c;

  // ---------------------------------------------------------------- TX
  assign load = (bit_cnt == LAST_BIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      bit_cnt <= '0;
      tx_sh   <= {LANES{COM_CHAR}};
    end else begin
      bit_cnt <= load ? '0 : bit_cnt + PH_W'(1);
      for (int i = 0; i < LANES; i++) begin
        if (load) begin
          tx_sh[i] <= (bus.enable && bus.valid_in[i]) ? bus.data_in[i*WIDTH +: WIDTH] : COM_CHAR;
        end else begin
          tx_sh[i] <= {tx_sh[i][WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  always_comb begin
    serial_q = '0;
    for (int i = 0; i < LANES; i++) begin
      serial_q[i] = tx_sh[i][WIDTH-1];
    end
  end

  assign bus.word_strobe = load;
  assign bus.serial_out  = serial_q;

  // ---------------------------------------------------------------- RX source
`ifdef PHY_LOOPBACK_EN
  logic unused_serial_in;
  assign unused_serial_in = ^bus.serial_in;
  assign rx_bit           = serial_q;
`else
  assign rx_bit = bus.serial_in;
`endif

  // ---------------------------------------------------------------- RX compare
  always_comb begin
    is_com = '0;
    at_bnd = '0;
    for (int i = 0; i < LANES; i++) begin
      is_com[i] = (rx_sh[i] == COM_CHAR);
      at_bnd[i] = (rx_ph[i] == LAST_BIT);
    end
  end

  // ---------------------------------------------------------------- sync FSM: state register
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        state_q[i] <= SEARCH;
        com_cnt[i] <= '0;
        rx_ph[i]   <= '0;
      end
      rx_sh  <= '0;
      dout_q <= '0;
      vout_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        state_q[i] <= state_nxt[i];
        com_cnt[i] <= com_cnt_nxt[i];
        // The phase counter restarts on a SEARCH hit so the next wrap lines up with a word edge.
        rx_ph[i]   <= (ph_clr[i] || at_bnd[i]) ? '0 : rx_ph[i] + PH_W'(1);
        rx_sh[i]   <= {rx_sh[i][WIDTH-2:0], rx_bit[i]};
      end
      dout_q <= dout_nxt;
      vout_q <= vout_nxt;
    end
  end

  // ---------------------------------------------------------------- sync FSM: next state
  // NOTE: every combinational output is given a default before any branch,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state_q;
    com_cnt_nxt = com_cnt;
    ph_clr      = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!bus.enable) begin
        state_nxt[i]   = SEARCH;
        com_cnt_nxt[i] = '0;
      end else begin
        unique case (state_q[i])
          SEARCH: begin
            if (is_com[i]) begin
              ph_clr[i]      = 1'b1;
              com_cnt_nxt[i] = CNT_W'(1);
              state_nxt[i]   = (SYNC_COUNT <= 1) ? ACTIVE : ALIGN;
            end
          end
          ALIGN: begin
            if (at_bnd[i]) begin
              if (is_com[i]) begin
                com_cnt_nxt[i] = com_cnt[i] + CNT_W'(1);
                if (com_cnt[i] + CNT_W'(1) == SYNC_CNT) begin
                  state_nxt[i] = ACTIVE;
                end
              end else begin
                com_cnt_nxt[i] = '0;
                state_nxt[i]   = SEARCH;
              end
            end
          end
          ACTIVE:  state_nxt[i] = ACTIVE;
          default: state_nxt[i] = SEARCH;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- sync FSM: outputs
  always_comb begin
    dout_nxt = dout_q;
    vout_nxt = vout_q;
    active_c = '0;
    for (int i = 0; i < LANES; i++) begin
      active_c[i] = (state_q[i] == ACTIVE);
      if (!bus.enable) begin
        dout_nxt[i] = '0;
        vout_nxt[i] = 1'b0;
      end else if (state_q[i] == ACTIVE && at_bnd[i]) begin
        // A COM at a word edge is idle: drop valid but keep the last word visible.
        if (is_com[i]) begin
          vout_nxt[i] = 1'b0;
        end else begin
          dout_nxt[i] = rx_sh[i];
          vout_nxt[i] = 1'b1;
        end
      end
    end
  end

  assign bus.data_out  = dout_q;
  assign bus.valid_out = vout_q;
  assign bus.active    = active_c;

endmodule

// File: tb/tb_phy_serdes_lanes.sv
// Self-checking bench for phy_serdes_lanes: random words against a word-level latency model,
// with an optional per-lane serial delay line standing in for the link.
module tb_phy_serdes_lanes;
  localparam int              LANES      = 2;
  localparam int              WIDTH      = 8;
  localparam int              SYNC_COUNT = 4;
  localparam logic [WIDTH-1:0] COM       = 8'hBC;

  typedef struct {
    longint           due;
    bit               vld;
    logic [WIDTH-1:0] data;
  } word_t;

  logic clk_8f = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_8f = ~clk_8f;

  phy_serdes_lanes_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

  phy_serdes_lanes #(
    .LANES(LANES), .WIDTH(WIDTH), .COM_CHAR(COM), .SYNC_COUNT(SYNC_COUNT)
  ) dut (
    .clk_8f(clk_8f),
    .reset (reset),
    .bus   (bus)
  );

  // Link model: lane l sees serial_out[l] delayed by dly[l] cycles.
  int                    dly [LANES];
  logic [LANES-1:0][7:0] hist = '1;
  logic [LANES-1:0]      sin;

  always @(posedge clk_8f)
    for (int l = 0; l < LANES; l++) hist[l] <= {hist[l][6:0], bus.serial_out[l]};

  always_comb begin
    sin = '0;
    for (int l = 0; l < LANES; l++)
      sin[l] = (dly[l] == 0) ? bus.serial_out[l] : hist[l][3'(dly[l] - 1)];
  end
  assign bus.serial_in = sin;

  // Reference model: each loaded word reaches the RX outputs WIDTH+1+delay edges after its load edge.
  word_t                  q     [LANES][$];
  logic [WIDTH-1:0]       exp_d [LANES];
  bit                     exp_v [LANES];
  longint                 cyc = 0;
  int                     n_vec = 0;
  int                     n_err = 0;
  bit                     force_word = 1'b0;
  logic [LANES*WIDTH-1:0] force_data;
  logic [LANES-1:0]       force_valid;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_8f);
    cyc++;
    @(negedge clk_8f);
  endtask

  task automatic model_clear();
    for (int l = 0; l < LANES; l++) begin
      q[l].delete();
      exp_d[l] = '0;
      exp_v[l] = 1'b0;
    end
  endtask

  // mode 0: acquiring (idle TX, valid_out must stay 0)
  // mode 1: random traffic, full check;  mode 2: idle TX, full check
  task automatic cycle(input int mode);
    word_t            w;
    logic             v;
    logic [WIDTH-1:0] d;
    tick();
    for (int l = 0; l < LANES; l++) begin
      while (q[l].size() > 0 && q[l][0].due <= cyc) begin
        w = q[l].pop_front();
        if (w.vld) begin
          exp_d[l] = w.data;
          exp_v[l] = 1'b1;
        end else begin
          exp_v[l] = 1'b0;
        end
      end
    end
    if (mode == 0) begin
      check("acq_valid_out", bus.valid_out, '0);
    end else begin
      for (int l = 0; l < LANES; l++) begin
        check($sformatf("active[%0d]", l), bus.active[l], 1);
        check($sformatf("valid_out[%0d]", l), bus.valid_out[l], exp_v[l]);
        check($sformatf("data_out[%0d]", l), bus.data_out[l*WIDTH +: WIDTH], exp_d[l]);
      end
    end
    for (int l = 0; l < LANES; l++) begin
      v = (mode == 1) && ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 7) == 0) ? COM : WIDTH'($urandom);
      if (bus.word_strobe && force_word) begin
        v = force_valid[l];
        d = force_data[l*WIDTH +: WIDTH];
      end
      bus.valid_in[l]                 = v;
      bus.data_in[l*WIDTH +: WIDTH]   = d;
      if (bus.word_strobe) begin
        w.due  = cyc + 1 + WIDTH + 1 + dly[l];
        w.vld  = bus.enable && v && (d != COM);
        w.data = d;
        q[l].push_back(w);
      end
    end
    if (bus.word_strobe) force_word = 1'b0;
  endtask

  task automatic acquire(input int bound, input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < bound && !ok; k++) begin
      cycle(0);
      ok = (bus.active == {LANES{1'b1}});
    end
    check(tag, bus.active, {LANES{1'b1}});
    repeat (WIDTH) cycle(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first_k;
    for (int l = 0; l < LANES; l++) dly[l] = 0;
    bus.enable   = 1'b1;
    bus.valid_in = '0;
    bus.data_in  = '0;
    model_clear();

    // 1: reset state
    repeat (3) tick();
    reset = 1'b0;
    check("rst_valid_out", bus.valid_out, 0);
    check("rst_active", bus.active, 0);
    check("rst_data_out", bus.data_out, 0);
    check("rst_serial_out", bus.serial_out, {LANES{COM[WIDTH-1]}});
    check("rst_word_strobe", bus.word_strobe, 0);

    // 2: idle link locks within the bound, valid_out stays low
    acquire((SYNC_COUNT + 2) * WIDTH, "t2_lock");

    // 3: directed word, latency and idle follow-up
    force_data  = {8'h3C, 8'hA5};
    force_valid = 2'b11;
    force_word  = 1'b1;
    for (int k = 0; k < 2 * WIDTH && force_word; k++) cycle(2);
    check("t3_strobe_seen", force_word, 0);
    repeat (WIDTH + 2) cycle(2);
    check("t3_data_out", bus.data_out, {8'h3C, 8'hA5});
    check("t3_valid_out", bus.valid_out, 2'b11);
    repeat (WIDTH) cycle(2);
    check("t3_idle_valid", bus.valid_out, 2'b00);
    check("t3_idle_hold", bus.data_out, {8'h3C, 8'hA5});
    repeat (40 * WIDTH) cycle(1);

    // 4: lane 1 skewed by 3 cycles on an external link
    repeat (2 * WIDTH) cycle(2);
    reset = 1'b1;
`ifndef PHY_LOOPBACK_EN
    dly[1] = 3;
`endif
    tick();
    reset = 1'b0;
    model_clear();
    acquire(4 * (SYNC_COUNT + 2) * WIDTH, "t4_lock_skew");
    repeat (40 * WIDTH) cycle(1);

    // 5: one-cycle enable drop while traffic flows
    bus.enable   = 1'b0;
    bus.valid_in = '0;
    model_clear();
    tick();
    check("t5_active", bus.active, 0);
    check("t5_valid_out", bus.valid_out, 0);
    check("t5_data_out", bus.data_out, 0);
    bus.enable = 1'b1;
    acquire(4 * (SYNC_COUNT + 2) * WIDTH, "t5_relock");
    repeat (40 * WIDTH) cycle(1);

    // 6: reset mid-word at bit_cnt == 3
    for (int k = 0; k < 2 * WIDTH && !bus.word_strobe; k++) cycle(2);
    check("t6_strobe_seen", bus.word_strobe, 1);
    repeat (4) cycle(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    check("t6_valid_out", bus.valid_out, 0);
    check("t6_active", bus.active, 0);
    check("t6_data_out", bus.data_out, 0);
    check("t6_serial_out", bus.serial_out, {LANES{COM[WIDTH-1]}});
    check("t6_word_strobe", bus.word_strobe, 0);
    first_k = -1;
    for (int k = 1; k <= WIDTH + 2 && first_k < 0; k++) begin
      tick();
      if (bus.word_strobe) first_k = k;
    end
    check("t6_strobe_edges_after_reset", first_k, WIDTH - 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
